// File: rtl/bsg_uart_link_packetizer.sv
// Packs UART link bytes into fixed-width RX packets and unpacks TX packets into link bytes.
// Both directions send the least-significant byte first. An inter-byte timeout discards partial RX packets.
module bsg_uart_link_packetizer #(
    parameter int uart_data_bits_p = 8,
    parameter int packet_width_p   = 32,
    parameter int timeout_cycles_p = 1000000
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [uart_data_bits_p+1:0] link_i,
    output logic [uart_data_bits_p+1:0] link_o,
    output logic [packet_width_p-1:0]   rx_data_o,
    output logic                        rx_v_o,
    input  logic                        rx_ready_i,
    input  logic [packet_width_p-1:0]   tx_data_i,
    input  logic                        tx_v_i,
    output logic                        tx_ready_o,
    output logic [7:0]                  drop_count_o
);

    localparam int bytes_lp      = packet_width_p / uart_data_bits_p;
    localparam int cnt_width_lp  = $clog2(bytes_lp);
    localparam int idle_width_lp = $clog2(timeout_cycles_p);
    localparam logic [cnt_width_lp-1:0]  last_byte_lp = cnt_width_lp'(bytes_lp - 1);
    localparam logic [idle_width_lp-1:0] idle_max_lp  = idle_width_lp'(timeout_cycles_p - 1);

    typedef enum logic {RX_COLLECT, RX_FULL} rx_state_e;
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

    rx_state_e                    rx_state_q, rx_state_d;
    logic [cnt_width_lp-1:0]      rx_cnt_q, rx_cnt_d;
    logic [packet_width_p-1:0]    rx_data_q, rx_data_d;
    logic [idle_width_lp-1:0]     idle_q, idle_d;
    logic [7:0]                   drop_count_q, drop_count_d;
    logic                         live_q, live_d;
    tx_state_e                    tx_state_q, tx_state_d;
    logic [cnt_width_lp-1:0]      tx_cnt_q, tx_cnt_d;
    logic [packet_width_p-1:0]    tx_data_q, tx_data_d;

    // The link is a packed {v, data, ready_and_rev} bundle.
    logic                         link_in_v;
    logic [uart_data_bits_p-1:0]  link_in_data;
    logic                         link_in_ready;
    assign {link_in_v, link_in_data, link_in_ready} = link_i;

    logic                         rx_byte_ready;
    logic                         rx_accept;
    logic                         tx_accept;
    logic                         tx_link_v;
    logic [uart_data_bits_p-1:0]  tx_byte;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rx_state_q   <= RX_COLLECT;
            rx_cnt_q     <= '0;
            rx_data_q    <= '0;
            idle_q       <= '0;
            drop_count_q <= '0;
            live_q       <= 1'b0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_data_q    <= '0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_data_q    <= rx_data_d;
            idle_q       <= idle_d;
            drop_count_q <= drop_count_d;
            live_q       <= live_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign live_d = 1'b1;

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_data_d    = rx_data_q;
        idle_d       = idle_q;
        drop_count_d = drop_count_q;
        case (rx_state_q)
            RX_COLLECT: begin
                if (rx_accept) begin
                    for (int i = 0; i < bytes_lp; i++) begin
                        if (rx_cnt_q == cnt_width_lp'(i)) begin
                            rx_data_d[i*uart_data_bits_p +: uart_data_bits_p] = link_in_data;
                        end
                    end
                    idle_d = '0;
                    if (rx_cnt_q == last_byte_lp) begin
                        rx_cnt_d   = '0;
                        rx_state_d = RX_FULL;
                    end else begin
                        rx_cnt_d = rx_cnt_q + 1'b1;
                    end
                end else if (rx_cnt_q == '0) begin
                    idle_d = '0;
                end else if (idle_q == idle_max_lp) begin
                    // Gap too long: discard the partial packet and count the loss.
                    rx_cnt_d  = '0;
                    idle_d    = '0;
                    rx_data_d = '0;
                    if (drop_count_q != 8'hFF) begin
                        drop_count_d = drop_count_q + 8'd1;
                    end
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            RX_FULL: begin
                if (rx_ready_i) begin
                    rx_state_d = RX_COLLECT;
                end
            end
            default: rx_state_d = RX_COLLECT;
        endcase
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_data_d  = tx_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_accept) begin
                    tx_data_d  = tx_data_i;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                if (link_in_ready) begin
                    if (tx_cnt_q == last_byte_lp) begin
                        tx_cnt_d   = '0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_cnt_d = tx_cnt_q + 1'b1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Ready outputs stay low until the cycle after reset release.
    always_comb begin
        rx_byte_ready = live_q & (rx_state_q == RX_COLLECT);
        rx_accept     = rx_byte_ready & link_in_v;
        rx_v_o        = (rx_state_q == RX_FULL);
        rx_data_o     = rx_data_q;
        drop_count_o  = drop_count_q;
        tx_ready_o    = live_q & (tx_state_q == TX_IDLE);
        tx_accept     = tx_ready_o & tx_v_i;
        tx_link_v     = (tx_state_q == TX_SEND);
        tx_byte       = '0;
        if (tx_link_v) begin
            for (int i = 0; i < bytes_lp; i++) begin
                if (tx_cnt_q == cnt_width_lp'(i)) begin
                    tx_byte = tx_data_q[i*uart_data_bits_p +: uart_data_bits_p];
                end
            end
        end
        link_o = {tx_link_v, tx_byte, rx_byte_ready};
    end

endmodule

// File: tb/tb_bsg_uart_link_packetizer.sv
// Self-checking bench for bsg_uart_link_packetizer: directed vector table, hand-written corner
// sequences, and a randomized run compared against a packet-level reference model.
module tb_bsg_uart_link_packetizer;

    localparam int W = 8;
    localparam int P = 32;
    localparam int T = 10;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          lv;
    logic [W-1:0]  ld;
    logic          lrr;
    logic [W+1:0]  link_i;
    logic [W+1:0]  link_o;
    logic [P-1:0]  rx_data_o;
    logic          rx_v_o;
    logic          rx_ready_i;
    logic [P-1:0]  tx_data_i;
    logic          tx_v_i;
    logic          tx_ready_o;
    logic [7:0]    drop_count_o;

    logic          out_lv;
    logic [W-1:0]  out_ld;
    logic          out_lrdy;

    assign link_i = {lv, ld, lrr};
    assign {out_lv, out_ld, out_lrdy} = link_o;

    bsg_uart_link_packetizer #(
        .uart_data_bits_p (W),
        .packet_width_p   (P),
        .timeout_cycles_p (T)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .link_i       (link_i),
        .link_o       (link_o),
        .rx_data_o    (rx_data_o),
        .rx_v_o       (rx_v_o),
        .rx_ready_i   (rx_ready_i),
        .tx_data_i    (tx_data_i),
        .tx_v_i       (tx_v_i),
        .tx_ready_o   (tx_ready_o),
        .drop_count_o (drop_count_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        lv;
        logic [7:0]  ld;
        logic        lrr;
        logic        rxr;
        logic        tv;
        logic [31:0] td;
        logic        e_rxv;
        logic [31:0] e_rxd;
        logic        e_lrdy;
        logic        e_lv;
        logic [7:0]  e_ld;
        logic        e_txr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic lv_, input logic [7:0] ld_, input logic lrr_,
                                input logic rxr_, input logic tv_, input logic [31:0] td_,
                                input logic erxv, input logic [31:0] erxd, input logic elrdy,
                                input logic elv, input logic [7:0] eld, input logic etxr);
        vec_t v;
        v.lv = lv_; v.ld = ld_; v.lrr = lrr_; v.rxr = rxr_; v.tv = tv_; v.td = td_;
        v.e_rxv = erxv; v.e_rxd = erxd; v.e_lrdy = elrdy;
        v.e_lv = elv; v.e_ld = eld; v.e_txr = etxr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        lv = 1'b0; ld = '0; lrr = 1'b0;
        rx_ready_i = 1'b0; tx_v_i = 1'b0; tx_data_i = '0;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        idle_inputs();
        step();
        step();
        reset_n_i = 1'b1;
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        lv = 1'b1;
        ld = b;
        step();
        lv = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " link_o"}, 32'(link_o), 32'h0);
        check({tag, " rx_v"}, 32'(rx_v_o), 32'h0);
        check({tag, " rx_data"}, rx_data_o, 32'h0);
        check({tag, " tx_ready"}, 32'(tx_ready_o), 32'h0);
        check({tag, " drop"}, 32'(drop_count_o), 32'h0);
    endtask

    // Reference-model state for the randomized phase.
    logic [7:0]  m_rx_q[$];
    logic [7:0]  m_tx_q[$];
    int          m_gap;
    bit          m_full;
    logic [31:0] m_pkt;
    int          m_drops;

    initial begin
        reset_n_i = 1'b0;
        idle_inputs();

        // Reset and release.
        step();
        step();
        check_all_zero("in_reset");
        reset_n_i = 1'b1;
        #1;
        check_all_zero("first_cycle");
        step();
        check("post_release link_ready", 32'(out_lrdy), 32'h1);
        check("post_release tx_ready", 32'(tx_ready_o), 32'h1);
        check("post_release link_v", 32'(out_lv), 32'h0);

        // RX assembly and backpressure, then TX serialization.
        vecs.push_back(mk(1, 8'h11, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h22, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h33, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h44, 0, 1, 0, 0, 1, 32'h44332211, 0, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h01, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h02, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h03, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h04, 0, 0, 0, 0, 1, 32'h04030201, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h55, 0, 0, 0, 0, 1, 32'h04030201, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h55, 0, 0, 0, 0, 1, 32'h04030201, 0, 0, 0, 1));
        vecs.push_back(mk(1, 8'h55, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h55, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h66, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h77, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 8'h88, 0, 1, 0, 0, 1, 32'h88776655, 0, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 32'hDEADBEEF, 0, 0, 1, 1, 8'hEF, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 1, 8'hBE, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 1, 8'hBE, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 1, 8'hAD, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 1, 8'hDE, 0));
        vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0, 0, 0, 1, 1, 8'hDE, 0));
        vecs.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 1, 0, 8'h00, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            lv = vecs[i].lv; ld = vecs[i].ld; lrr = vecs[i].lrr;
            rx_ready_i = vecs[i].rxr; tx_v_i = vecs[i].tv; tx_data_i = vecs[i].td;
            step();
            check($sformatf("vec%0d rx_v", i), 32'(rx_v_o), 32'(vecs[i].e_rxv));
            if (vecs[i].e_rxv) check($sformatf("vec%0d rx_data", i), rx_data_o, vecs[i].e_rxd);
            check($sformatf("vec%0d link_ready", i), 32'(out_lrdy), 32'(vecs[i].e_lrdy));
            check($sformatf("vec%0d link_v", i), 32'(out_lv), 32'(vecs[i].e_lv));
            if (vecs[i].e_lv) check($sformatf("vec%0d link_data", i), 32'(out_ld), 32'(vecs[i].e_ld));
            check($sformatf("vec%0d tx_ready", i), 32'(tx_ready_o), 32'(vecs[i].e_txr));
            check($sformatf("vec%0d drop", i), 32'(drop_count_o), 32'h0);
        end

        // Inter-byte timeout and the expiry-cycle race.
        idle_inputs();
        rx_ready_i = 1'b1;
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (9) step();
        check("timeout before_expiry", 32'(drop_count_o), 32'h0);
        step();
        check("timeout drop", 32'(drop_count_o), 32'h1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("after_drop rx_v", 32'(rx_v_o), 32'h1);
        check("after_drop rx_data", rx_data_o, 32'h04030201);
        step();
        check("after_drop consumed", 32'(rx_v_o), 32'h0);
        send_byte(8'hA1);
        send_byte(8'hA2);
        repeat (9) step();
        send_byte(8'hA3);
        check("expiry_race drop", 32'(drop_count_o), 32'h1);
        send_byte(8'hA4);
        check("expiry_race rx_v", 32'(rx_v_o), 32'h1);
        check("expiry_race rx_data", rx_data_o, 32'hA4A3A2A1);
        step();

        // Asynchronous reset in the middle of TX and RX activity.
        rx_ready_i = 1'b0;
        tx_v_i = 1'b1; tx_data_i = 32'h11223344;
        lv = 1'b1; ld = 8'h77; lrr = 1'b0;
        step();
        tx_v_i = 1'b0; lv = 1'b0; lrr = 1'b1;
        step();
        step();
        check("mid_tx link_v", 32'(out_lv), 32'h1);
        check("mid_tx link_data", 32'(out_ld), 32'h22);
        #2;
        reset_n_i = 1'b0;
        lrr = 1'b0;
        #1;
        check_all_zero("async_reset");
        step();
        reset_n_i = 1'b1;
        #1;
        check_all_zero("release_cycle");
        step();
        check("rearm link_ready", 32'(out_lrdy), 32'h1);
        check("rearm tx_ready", 32'(tx_ready_o), 32'h1);
        check("rearm link_v", 32'(out_lv), 32'h0);
        tx_v_i = 1'b1; tx_data_i = 32'h01020304; lrr = 1'b1;
        step();
        tx_v_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("rearm tx_v%0d", k), 32'(out_lv), 32'h1);
            check($sformatf("rearm tx_byte%0d", k), 32'(out_ld), (32'h01020304 >> (8 * k)) & 32'hFF);
            step();
        end
        check("rearm tx_done", 32'(tx_ready_o), 32'h1);
        lrr = 1'b0;
        send_byte(8'h04);
        send_byte(8'h03);
        send_byte(8'h02);
        send_byte(8'h01);
        check("rearm rx_v", 32'(rx_v_o), 32'h1);
        check("rearm rx_data", rx_data_o, 32'h01020304);
        rx_ready_i = 1'b1;
        step();
        check("rearm rx_consumed", 32'(rx_v_o), 32'h0);

        // Randomized traffic on both paths against the reference model.
        do_reset();
        m_rx_q.delete(); m_tx_q.delete();
        m_gap = 0; m_full = 0; m_pkt = '0; m_drops = 0;
        begin
            int rx_wait;
            bit rx_acc;
            bit tx_acc;
            rx_wait = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                if (!lv) begin
                    if (rx_wait == 0) begin
                        lv = 1'b1;
                        ld = 8'($urandom);
                    end else begin
                        rx_wait--;
                    end
                end
                rx_ready_i = ($urandom_range(0, 3) != 0);
                lrr = 1'($urandom_range(0, 1));
                if (!tx_v_i && $urandom_range(0, 3) == 0) begin
                    tx_v_i = 1'b1;
                    tx_data_i = $urandom;
                end

                check("rand rx_v", 32'(rx_v_o), 32'(m_full));
                if (m_full) check("rand rx_data", rx_data_o, m_pkt);
                check("rand link_ready", 32'(out_lrdy), 32'(!m_full));
                check("rand drop", 32'(drop_count_o), 32'(m_drops));
                check("rand tx_ready", 32'(tx_ready_o), 32'(m_tx_q.size() == 0));
                check("rand link_v", 32'(out_lv), 32'(m_tx_q.size() != 0));
                if (m_tx_q.size() != 0) check("rand link_data", 32'(out_ld), 32'(m_tx_q[0]));

                rx_acc = 0;
                if (m_full) begin
                    if (rx_ready_i) m_full = 0;
                end else if (lv) begin
                    rx_acc = 1;
                    m_rx_q.push_back(ld);
                    m_gap = 0;
                    if (m_rx_q.size() == P / W) begin
                        m_pkt = '0;
                        for (int i = 0; i < P / W; i++) m_pkt |= 32'(m_rx_q[i]) << (8 * i);
                        m_full = 1;
                        m_rx_q.delete();
                    end
                end else if (m_rx_q.size() != 0) begin
                    m_gap++;
                    if (m_gap == T) begin
                        m_rx_q.delete();
                        m_gap = 0;
                        if (m_drops < 255) m_drops++;
                    end
                end

                tx_acc = 0;
                if (m_tx_q.size() == 0) begin
                    if (tx_v_i) begin
                        tx_acc = 1;
                        for (int i = 0; i < P / W; i++) m_tx_q.push_back(8'(tx_data_i >> (8 * i)));
                    end
                end else if (lrr) begin
                    void'(m_tx_q.pop_front());
                end

                step();

                if (rx_acc) begin
                    lv = 1'b0;
                    if ($urandom_range(0, 9) < 7) rx_wait = $urandom_range(0, 2);
                    else rx_wait = $urandom_range(7, 13);
                end
                if (tx_acc) tx_v_i = 1'b0;
            end
        end

        // Drop counter saturation.
        do_reset();
        rx_ready_i = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            send_byte(8'(n));
            repeat (T) step();
            if (n == 1)   check("sat drop1", 32'(drop_count_o), 32'd1);
            if (n == 254) check("sat drop254", 32'(drop_count_o), 32'd254);
            if (n == 255) check("sat drop255", 32'(drop_count_o), 32'd255);
        end
        check("sat final", 32'(drop_count_o), 32'd255);
        check("sat link_ready", 32'(out_lrdy), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_uart_link_packetizer.md
# bsg_uart_link_packetizer

Converts between the UART byte stream carried on a `bsg_ready_and_link_sif` link and fixed-width packets for the on-chip command path. It sits directly on the link side of the UART AXI-Lite bridge and is its only link peer.
- **RX:** assembles `packet_width_p/uart_data_bits_p` consecutive bytes, least-significant first, into one packet. A partial packet is dropped when the gap between bytes exceeds the inter-byte timeout.
- **TX:** serializes outgoing packets into bytes, least-significant first.

## Interface
Parameters:
- `uart_data_bits_p`, default 8: byte width; equals the link data width.
- `packet_width_p`, default 32: packet width. Must be an integer multiple of `uart_data_bits_p`, at least 2 bytes. `bytes_lp = packet_width_p/uart_data_bits_p`.
- `timeout_cycles_p`, default 1000000: inter-byte timeout in cycles, ≥ 2.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `link_i`  in  `bsg_ready_and_link_sif_width(uart_data_bits_p)`
  - `.v`, `.data`: bytes arriving from the bridge.
  - `.ready_and_rev`: bridge accepts our TX byte.
- `link_o`  out  same width
  - `.v`, `.data`: TX byte to the bridge.
  - `.ready_and_rev`: we accept an RX byte.
- `rx_data_o`  out  `packet_width_p`  assembled packet.
- `rx_v_o`  out  1  `rx_data_o` valid.
- `rx_ready_i`  in  1  consumer accepts the packet (ready/valid).
- `tx_data_i`  in  `packet_width_p`  packet to send.
- `tx_v_i`  in  1  `tx_data_i` valid.
- `tx_ready_o`  out  1  block accepts a TX packet.
- `drop_count_o`  out  8  saturating count of RX packets discarded by timeout.

## Operation
- **Handshake:** a transfer occurs on a cycle where valid and ready are both high at the rising edge of `clk_i`. Valid never depends on ready.

RX FSM, states `RX_COLLECT` and `RX_FULL`:
- `link_o.ready_and_rev = live_r & (state == RX_COLLECT)`.
- **Byte accept:** in `RX_COLLECT`, an accepted byte is written to `rx_data_r[rx_cnt_r*uart_data_bits_p +: uart_data_bits_p]` and `rx_cnt_r` increments.
- **Last byte:** accepting byte `bytes_lp-1` moves the FSM to `RX_FULL` and clears `rx_cnt_r`.
- `RX_FULL`:
  - `rx_v_o = 1`; `rx_data_o = rx_data_r`, held stable.
  - On `rx_ready_i`, return to `RX_COLLECT`.
  - No bytes are accepted in this state; the link backpressures.
- **Timeout counter `idle_r`:**
  - Counts only in `RX_COLLECT` with `rx_cnt_r != 0` and no byte accepted in that cycle.
  - Clears on every accepted byte and whenever `rx_cnt_r == 0`.
  - When `idle_r == timeout_cycles_p-1` and no byte is accepted: `rx_cnt_r <= 0`, `idle_r <= 0`, `rx_data_r <= 0`, and `drop_count_o` increments, saturating at 255.
  - A byte accepted in the expiry cycle wins: no drop, counter cleared.

TX FSM, states `TX_IDLE` and `TX_SEND`:
- `tx_ready_o = live_r & (state == TX_IDLE)`.
- On a handshake, latch `tx_data_i` into `tx_data_r`, set `tx_cnt_r = 0`, and go to `TX_SEND`.
- `TX_SEND`:
  - `link_o.v = 1`; `link_o.data = tx_data_r[tx_cnt_r*uart_data_bits_p +: uart_data_bits_p]`.
  - On `link_i.ready_and_rev`, `tx_cnt_r` increments.
  - The handshake on byte `bytes_lp-1` returns the FSM to `TX_IDLE`.
- RX and TX are fully independent. Simultaneous activity on both paths is legal and has no interaction.

## Timing
- **Reset:** while `reset_n_i` is low, all flops are asynchronously cleared:
  - RX state = `RX_COLLECT`, TX state = `TX_IDLE`.
  - Counters and data registers = 0.
  - `live_r = 0`.
- **After release:** `live_r` sets on the first rising edge after `reset_n_i` goes high.
  - Every output is 0 during reset and on the first cycle after release.
  - `link_o.ready_and_rev` and `tx_ready_o` rise one cycle after release.
- **Reset mid-operation:**
  - A partial RX packet is lost.
  - An unconsumed full packet is lost.
  - A TX packet stops at its current byte; remaining bytes are never sent.
  - `drop_count_o` returns to 0.
- **RX latency:** `rx_v_o` rises the cycle after the last byte handshake. With `rx_ready_i` held high, the next byte is accepted one cycle after the packet handshake.
- **TX latency:** the first byte is valid the cycle after the packet handshake. Sustained throughput is `bytes_lp+1` cycles per packet with no backpressure, because `tx_ready_o` is high only in `TX_IDLE`.
- **Boundaries:**
  - The timeout never fires when `rx_cnt_r == 0` or in `RX_FULL`.
  - `drop_count_o` holds at 255.
  - `tx_cnt_r` and `rx_cnt_r` never exceed `bytes_lp-1`.

## Test plan
Defaults assumed (8-bit bytes, 32-bit packets); the timeout test overrides `timeout_cycles_p` to 10.
1. **RX assembly:** bytes 0x11, 0x22, 0x33, 0x44 on back-to-back cycles, `rx_ready_i = 1` -> `rx_data_o = 0x44332211`, `rx_v_o` high for exactly one cycle, `drop_count_o = 0`.
2. **RX backpressure:** hold `rx_ready_i = 0` after a full packet and offer byte 0x55 -> `link_o.ready_and_rev = 0` and `rx_data_o` stable. Raise `rx_ready_i` -> 0x55 is accepted one cycle after the packet handshake and becomes byte 0 of the next packet.
3. **Timeout** (`timeout_cycles_p = 10`):
   - Send 0xAA, 0xBB, then idle 10 cycles -> `drop_count_o = 1`.
   - Then send 0x01, 0x02, 0x03, 0x04 -> `rx_data_o = 0x04030201`.
   - A third byte arriving on idle cycle 9 (the expiry cycle) -> no drop.
4. **TX serialization:** `tx_data_i = 0xDEADBEEF` with `link_i.ready_and_rev` toggling 1,0,1,1,0,1 -> `link_o.data` sequence 0xEF, 0xBE, 0xAD, 0xDE; `tx_ready_o` low until the cycle after the 0xDE handshake.
5. **Reset:**
   - Assert `reset_n_i` low asynchronously mid-TX (after 2 bytes) and mid-RX (after 1 byte) -> all outputs 0 immediately.
   - After release, ready outputs rise one cycle later.
   - A new packet 0x01020304 is sent and received intact.
6. **Saturation:** force 260 timeouts -> `drop_count_o = 255`.
